mc_control_fsm: RTL and testbench

//  Main multi-cycle controller for the processor datapath. Sequences the Reg-based

---
 rtl/mc_control_fsm_pkg.sv | 58 +++++
 rtl/mc_control_fsm.sv | 169 ++++++++++++++++
 tb/tb_mc_control_fsm.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multi-cycle controller and the ALU decoder:
// opcode values, controller state encodings and datapath select codes.
package mc_control_fsm_pkg;

   localparam int OP_W    = 6;
   localparam int STATE_W = 4;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // Controller states, one datapath micro-step each
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   // ALU B operand select
   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   // ALU operation class
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // Next-PC source select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // True for every opcode the controller knows how to sequence
   function automatic logic is_supported_op(input logic [5:0] op);
      logic ok;
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
         default:                                        ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mc_control_fsm.sv
// Multi-cycle main controller. Moore FSM: every control output is decoded
// from the current state, except that FETCH qualifies PC/IR loads with
// mem_ready and pc_en folds in the ALU zero flag for branches.
module mc_control_fsm
   import mc_control_fsm_pkg::*;
#(
   parameter int OP_W    = 6,
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [OP_W-1:0]    opcode,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_en,
   output logic               iord,
   output logic               mem_rd,
   output logic               mem_we,
   output logic               ir_we,
   output logic               rf_we,
   output logic               regdst,
   output logic               mem2reg,
   output logic               alusrca,
   output logic [1:0]         alusrcb,
   output logic [1:0]         aluop,
   output logic [1:0]         pcsrc,
   output logic               illegal,
   output logic [STATE_W-1:0] state_dbg
);

   state_t state_r;
   state_t next_state_s;
   logic   illegal_r;
   logic   set_illegal_s;
   logic   pc_write_s;
   logic   branch_s;

   // State register and sticky illegal-opcode flag; reset overrides any move
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= S_FETCH;
         illegal_r <= 1'b0;
      end else begin
         state_r <= next_state_s;
         if (set_illegal_s) begin
            illegal_r <= 1'b1;
         end
      end
   end

   // Next-state selection from current state, opcode and memory handshake
   always_comb begin
      next_state_s  = state_r;
      set_illegal_s = 1'b0;
      case (state_r)
         S_FETCH: begin
            if (mem_ready) next_state_s = S_DECODE;
            else           next_state_s = S_FETCH;
         end
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: next_state_s = S_MEMADR;
               OP_RTYPE:     next_state_s = S_EXEC;
               OP_BEQ:       next_state_s = S_BRANCH;
               OP_ADDI:      next_state_s = S_ADDIEX;
               OP_J:         next_state_s = S_JUMP;
               default: begin
                  next_state_s  = S_FETCH;
                  set_illegal_s = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            // Opcode cannot change mid-instruction; anything else restarts
            case (opcode)
               OP_LW:   next_state_s = S_MEMRD;
               OP_SW:   next_state_s = S_MEMWR;
               default: next_state_s = S_FETCH;
            endcase
         end
         S_MEMRD: begin
            if (mem_ready) next_state_s = S_MEMWB;
            else           next_state_s = S_MEMRD;
         end
         S_MEMWR: begin
            if (mem_ready) next_state_s = S_FETCH;
            else           next_state_s = S_MEMWR;
         end
         S_EXEC:   next_state_s = S_ALUWB;
         S_ADDIEX: next_state_s = S_ADDIWB;
         S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: next_state_s = S_FETCH;
         default:  next_state_s = S_FETCH;
      endcase
   end

   // Control decode: everything not named in a state stays 0
   always_comb begin
      pc_write_s = 1'b0;
      branch_s   = 1'b0;
      iord       = 1'b0;
      mem_rd     = 1'b0;
      mem_we     = 1'b0;
      ir_we      = 1'b0;
      rf_we      = 1'b0;
      regdst     = 1'b0;
      mem2reg    = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = SRCB_B;
      aluop      = ALUOP_ADD;
      pcsrc      = PCSRC_ALU;
      case (state_r)
         S_FETCH: begin
            // PC+4 and IR load happen only on the cycle the fetch completes
            mem_rd     = 1'b1;
            ir_we      = mem_ready;
            pc_write_s = mem_ready;
            alusrcb    = SRCB_FOUR;
         end
         S_DECODE: begin
            alusrcb = SRCB_IMM_SH;
         end
         S_MEMADR, S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
         end
         S_MEMRD: begin
            mem_rd = 1'b1;
            iord   = 1'b1;
         end
         S_MEMWB: begin
            rf_we   = 1'b1;
            mem2reg = 1'b1;
         end
         S_MEMWR: begin
            mem_we = 1'b1;
            iord   = 1'b1;
         end
         S_EXEC: begin
            alusrca = 1'b1;
            aluop   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            rf_we  = 1'b1;
            regdst = 1'b1;
         end
         S_BRANCH: begin
            alusrca  = 1'b1;
            aluop    = ALUOP_SUB;
            pcsrc    = PCSRC_ALUOUT;
            branch_s = 1'b1;
         end
         S_ADDIWB: begin
            rf_we = 1'b1;
         end
         S_JUMP: begin
            pcsrc      = PCSRC_JUMP;
            pc_write_s = 1'b1;
         end
         default: begin
            pc_write_s = 1'b0;
         end
      endcase
   end

   assign pc_en     = pc_write_s | (branch_s & zero);
   assign illegal   = illegal_r;
   assign state_dbg = STATE_W'(state_r);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: a per-cycle vector table for the main
// instruction flows plus hand-written sequences for stalls, sticky illegal,
// reset during a memory wait and per-instruction latency.
module tb_mc_control_fsm;

   // Bench-local state numbering (matches the design's encoding)
   localparam logic [3:0] ST_F   = 4'd0,  ST_D   = 4'd1,  ST_MA  = 4'd2;
   localparam logic [3:0] ST_MR  = 4'd3,  ST_MWB = 4'd4,  ST_MW  = 4'd5;
   localparam logic [3:0] ST_EX  = 4'd6,  ST_AWB = 4'd7,  ST_BR  = 4'd8;
   localparam logic [3:0] ST_AX  = 4'd9,  ST_AXW = 4'd10, ST_J   = 4'd11;

   localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011;
   localparam logic [5:0] O_BEQ = 6'b000100, O_ADDI = 6'b001000, O_J = 6'b000010;
   localparam logic [5:0] O_BAD = 6'b111111;

   // ctl = {pc_en,iord,mem_rd,mem_we,ir_we,rf_we,regdst,mem2reg,alusrca,
   //        alusrcb[1:0],aluop[1:0],pcsrc[1:0],illegal}
   localparam logic [15:0] C_FETCH_R = 16'b1_0_1_0_1_0_0_0_0_01_00_00_0;
   localparam logic [15:0] C_FETCH_N = 16'b0_0_1_0_0_0_0_0_0_01_00_00_0;
   localparam logic [15:0] C_DECODE  = 16'b0_0_0_0_0_0_0_0_0_11_00_00_0;
   localparam logic [15:0] C_IMMADR  = 16'b0_0_0_0_0_0_0_0_1_10_00_00_0;
   localparam logic [15:0] C_MEMRD   = 16'b0_1_1_0_0_0_0_0_0_00_00_00_0;
   localparam logic [15:0] C_MEMWB   = 16'b0_0_0_0_0_1_0_1_0_00_00_00_0;
   localparam logic [15:0] C_MEMWR   = 16'b0_1_0_1_0_0_0_0_0_00_00_00_0;
   localparam logic [15:0] C_EXEC    = 16'b0_0_0_0_0_0_0_0_1_00_10_00_0;
   localparam logic [15:0] C_ALUWB   = 16'b0_0_0_0_0_1_1_0_0_00_00_00_0;
   localparam logic [15:0] C_BR_T    = 16'b1_0_0_0_0_0_0_0_1_00_01_01_0;
   localparam logic [15:0] C_BR_N    = 16'b0_0_0_0_0_0_0_0_1_00_01_01_0;
   localparam logic [15:0] C_ADDIWB  = 16'b0_0_0_0_0_1_0_0_0_00_00_00_0;
   localparam logic [15:0] C_JUMP    = 16'b1_0_0_0_0_0_0_0_0_00_00_10_0;

   logic       clk;
   logic       rst;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pc_en, iord, mem_rd, mem_we, ir_we, rf_we, regdst, mem2reg, alusrca;
   logic [1:0] alusrcb, aluop, pcsrc;
   logic       illegal;
   logic [3:0] state_dbg;
   logic [15:0] ctl;

   int errors = 0;
   int checks = 0;

   mc_control_fsm #(.OP_W(6), .STATE_W(4)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_en(pc_en), .iord(iord), .mem_rd(mem_rd), .mem_we(mem_we), .ir_we(ir_we),
      .rf_we(rf_we), .regdst(regdst), .mem2reg(mem2reg), .alusrca(alusrca),
      .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .illegal(illegal),
      .state_dbg(state_dbg)
   );

   assign ctl = {pc_en, iord, mem_rd, mem_we, ir_we, rf_we, regdst, mem2reg,
                 alusrca, alusrcb, aluop, pcsrc, illegal};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic        zero;
      logic        mr;
      logic        chk;
      logic [3:0]  st;
      logic [15:0] ctl;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic [5:0] op, input logic z,
                      input logic mr, input logic c, input logic [3:0] st,
                      input logic [15:0] cv);
      vec_t v;
      v.rst = r; v.op = op; v.zero = z; v.mr = mr; v.chk = c; v.st = st; v.ctl = cv;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Two reset cycles; returns 1 time unit after the edge with state at FETCH
   task automatic do_reset();
      rst = 1'b1;
      mem_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [5:0] op;
      int         lat;
      string      name;
   } lat_t;

   lat_t lats[6];

   initial begin
      int cyc;
      int cnt;
      bit done;

      rst = 1'b1; opcode = 6'b0; zero = 1'b0; mem_ready = 1'b0;

      // ---------------- per-cycle table ----------------
      add(1'b1, O_R,    1'b0, 1'b0, 1'b0, ST_F,   C_FETCH_N);
      add(1'b1, O_R,    1'b0, 1'b0, 1'b1, ST_F,   C_FETCH_N);  // reset state
      // LW
      add(1'b0, O_LW,   1'b0, 1'b1, 1'b1, ST_F,   C_FETCH_R);
      add(1'b0, O_LW,   1'b1, 1'b1, 1'b1, ST_D,   C_DECODE);
      add(1'b0, O_LW,   1'b1, 1'b1, 1'b1, ST_MA,  C_IMMADR);
      add(1'b0, O_LW,   1'b1, 1'b1, 1'b1, ST_MR,  C_MEMRD);
      add(1'b0, O_LW,   1'b1, 1'b1, 1'b1, ST_MWB, C_MEMWB);
      // RTYPE
      add(1'b0, O_R,    1'b0, 1'b1, 1'b1, ST_F,   C_FETCH_R);
      add(1'b0, O_R,    1'b0, 1'b1, 1'b1, ST_D,   C_DECODE);
      add(1'b0, O_R,    1'b1, 1'b1, 1'b1, ST_EX,  C_EXEC);
      add(1'b0, O_R,    1'b1, 1'b1, 1'b1, ST_AWB, C_ALUWB);
      // BEQ taken
      add(1'b0, O_BEQ,  1'b0, 1'b1, 1'b1, ST_F,   C_FETCH_R);
      add(1'b0, O_BEQ,  1'b0, 1'b1, 1'b1, ST_D,   C_DECODE);
      add(1'b0, O_BEQ,  1'b1, 1'b1, 1'b1, ST_BR,  C_BR_T);
      // BEQ not taken
      add(1'b0, O_BEQ,  1'b0, 1'b1, 1'b1, ST_F,   C_FETCH_R);
      add(1'b0, O_BEQ,  1'b1, 1'b1, 1'b1, ST_D,   C_DECODE);
      add(1'b0, O_BEQ,  1'b0, 1'b1, 1'b1, ST_BR,  C_BR_N);
      // ADDI
      add(1'b0, O_ADDI, 1'b0, 1'b1, 1'b1, ST_F,   C_FETCH_R);
      add(1'b0, O_ADDI, 1'b0, 1'b1, 1'b1, ST_D,   C_DECODE);
      add(1'b0, O_ADDI, 1'b1, 1'b1, 1'b1, ST_AX,  C_IMMADR);
      add(1'b0, O_ADDI, 1'b1, 1'b1, 1'b1, ST_AXW, C_ADDIWB);
      // J
      add(1'b0, O_J,    1'b0, 1'b1, 1'b1, ST_F,   C_FETCH_R);
      add(1'b0, O_J,    1'b0, 1'b1, 1'b1, ST_D,   C_DECODE);
      add(1'b0, O_J,    1'b0, 1'b1, 1'b1, ST_J,   C_JUMP);
      // SW with one fetch stall
      add(1'b0, O_SW,   1'b1, 1'b0, 1'b1, ST_F,   C_FETCH_N);
      add(1'b0, O_SW,   1'b0, 1'b1, 1'b1, ST_F,   C_FETCH_R);
      add(1'b0, O_SW,   1'b0, 1'b1, 1'b1, ST_D,   C_DECODE);
      add(1'b0, O_SW,   1'b0, 1'b1, 1'b1, ST_MA,  C_IMMADR);
      add(1'b0, O_SW,   1'b1, 1'b1, 1'b1, ST_MW,  C_MEMWR);
      add(1'b0, O_R,    1'b0, 1'b1, 1'b1, ST_F,   C_FETCH_R);

      foreach (vecs[i]) begin
         rst = vecs[i].rst; opcode = vecs[i].op; zero = vecs[i].zero;
         mem_ready = vecs[i].mr;
         @(negedge clk);
         if (vecs[i].chk) begin
            check($sformatf("vec%0d_state", i), 32'(state_dbg), 32'(vecs[i].st));
            check($sformatf("vec%0d_ctl", i),   32'(ctl),       32'(vecs[i].ctl));
         end
         @(posedge clk);
         #1;
      end

      // ---------------- SW with 3 wait cycles in MEMWR ----------------
      do_reset();
      opcode = O_SW; mem_ready = 1'b1; zero = 1'b0;
      next_cycle(); next_cycle(); next_cycle();
      check("sw_reach_memwr", 32'(state_dbg), 32'(ST_MW));
      mem_ready = 1'b0;
      cnt = 0; done = 1'b0;
      for (int k = 0; k < 16 && !done; k++) begin
         @(negedge clk);
         if (state_dbg != ST_MW) begin
            done = 1'b1;
         end else begin
            if (mem_we) cnt++;
            @(posedge clk);
            #1;
            if (cnt >= 3) mem_ready = 1'b1;
         end
      end
      check("sw_wait_done", 32'(done), 32'd1);
      check("sw_mem_we_cycles", 32'(cnt), 32'd4);
      check("sw_then_fetch", 32'(state_dbg), 32'(ST_F));
      check("sw_fetch_no_we", 32'(mem_we), 32'd0);

      // ---------------- sticky illegal ----------------
      do_reset();
      opcode = O_BAD; mem_ready = 1'b1;
      next_cycle();
      check("ill_decode", 32'(state_dbg), 32'(ST_D));
      check("ill_not_yet", 32'(illegal), 32'd0);
      next_cycle();
      check("ill_back_fetch", 32'(state_dbg), 32'(ST_F));
      check("ill_set", 32'(illegal), 32'd1);
      opcode = O_J;
      next_cycle(); next_cycle();
      check("ill_j_state", 32'(state_dbg), 32'(ST_J));
      check("ill_sticky", 32'(illegal), 32'd1);
      next_cycle();
      check("ill_sticky_fetch", 32'(illegal), 32'd1);
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      check("ill_cleared_rst", 32'(illegal), 32'd0);

      // ---------------- reset during MEMRD wait ----------------
      do_reset();
      opcode = O_LW; mem_ready = 1'b1;
      next_cycle(); next_cycle();
      mem_ready = 1'b0;
      next_cycle();
      @(negedge clk);
      check("rstwait_memrd", 32'(state_dbg), 32'(ST_MR));
      check("rstwait_rd_req", 32'({mem_rd, iord}), 32'(2'b11));
      @(posedge clk);
      #1;
      check("rstwait_still", 32'(state_dbg), 32'(ST_MR));
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check("rstwait_fetch", 32'(state_dbg), 32'(ST_F));
      check("rstwait_ctl", 32'(ctl), 32'(C_FETCH_N));
      mem_ready = 1'b1;
      next_cycle();
      check("rstwait_refetch", 32'(state_dbg), 32'(ST_D));

      // ---------------- latency, mem_ready tied high ----------------
      lats[0] = '{O_LW,   5, "lat_lw"};
      lats[1] = '{O_SW,   4, "lat_sw"};
      lats[2] = '{O_R,    4, "lat_rtype"};
      lats[3] = '{O_ADDI, 4, "lat_addi"};
      lats[4] = '{O_BEQ,  3, "lat_beq"};
      lats[5] = '{O_J,    3, "lat_j"};
      foreach (lats[i]) begin
         do_reset();
         opcode = lats[i].op; mem_ready = 1'b1; zero = 1'b0;
         cyc = 0; done = 1'b0;
         for (int k = 0; k < 20 && !done; k++) begin
            next_cycle();
            cyc++;
            if (state_dbg == ST_F) done = 1'b1;
         end
         check(lats[i].name, 32'(cyc), 32'(lats[i].lat));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
